// File: rtl/div_pkg.sv
// Shared widths, FSM state type and counter width for the sequential divider.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor with a 4-bit ripple adder (a + ~d + 1)
// and keep the difference only if the shifted value was >= the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_r,       // current partial remainder (always < divisor)
  input  logic                 i_q_msb,   // dividend bit shifted in this step
  input  logic [DIVISOR_W-1:0] i_d,       // divisor
  output logic [DIVISOR_W-1:0] o_r_next,  // partial remainder after this step
  output logic                 o_q_bit    // quotient bit produced by this step
);

  // Low 4 bits of T = {R, Q msb}; bit 4 of T is R's msb and is handled via w_ge.
  logic [DIVISOR_W-1:0] w_t_lo;
  logic [DIVISOR_W-1:0] w_sub;
  logic [DIVISOR_W:0]   w_c;
  logic                 w_ge;

  assign w_t_lo = {i_r[DIVISOR_W-2:0], i_q_msb};
  assign w_c[0] = 1'b1;

  // Full-adder chain computing T[3:0] + ~D + 1.
  for (genvar i = 0; i < DIVISOR_W; i++) begin : g_fa
    assign w_sub[i]   = w_t_lo[i] ^ ~i_d[i] ^ w_c[i];
    assign w_c[i+1]   = (w_t_lo[i] & ~i_d[i]) | (w_c[i] & (w_t_lo[i] ^ ~i_d[i]));
  end

  // T >= D when T overflows 4 bits or the subtraction produced no borrow
  // (carry out = 1). Because T < 2D the kept remainder always fits in 4 bits.
  assign w_ge     = i_r[DIVISOR_W-1] | w_c[DIVISOR_W];
  assign o_r_next = w_ge ? w_sub : w_t_lo;
  assign o_q_bit  = w_ge;

endmodule

// File: rtl/seq_divider_ctrl.sv
// Sequential restoring divider controller: 8-bit dividend / 4-bit divisor, one
// quotient bit per clock through a single shared div_step. start/ready/done
// handshake; divide-by-zero finishes immediately with a saturated quotient.
module seq_divider_ctrl
  import div_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  div_state_t            r_state;
  logic [CNT_W-1:0]      r_count;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_r;
  logic [DIVISOR_W-1:0]  r_d;
  logic                  r_dbz;
  logic                  r_done;
  logic                  r_ready;

  logic [DIVISOR_W-1:0]  w_r_next;
  logic                  w_q_bit;

  div_step u_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[DIVIDEND_W-1]),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  // FSM, iteration counter and Q/R/D datapath registers with registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments so every register in this
  // block samples pre-edge values, e.g. the RUN step reads the old r_q/r_r.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_d     <= divisor_i;
            r_count <= '0;
            r_ready <= 1'b0;
            if (divisor_i == '0) begin
              r_q     <= '1;
              r_r     <= dividend_i[DIVISOR_W-1:0];
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_q     <= dividend_i;
              r_r     <= '0;
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_q     <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_r     <= w_r_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_CNT) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o       = r_ready;
  assign done_o        = r_done;
  assign quotient_o    = r_q;
  assign remainder_o   = r_r;
  assign div_by_zero_o = r_dbz;

endmodule
